// File: rtl/img_pkg.sv
// Shared encodings for the image scan controller: operation codes, FSM states, beat geometry.
package img_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VSYNC = 3'd1,
    ST_HSYNC = 3'd2,
    ST_DATA  = 3'd3,
    ST_DONE  = 3'd4
  } scan_state_e;

  localparam logic [2:0] OP_PASS   = 3'd0;
  localparam logic [2:0] OP_BRIGHT = 3'd1;
  localparam logic [2:0] OP_INVERT = 3'd2;
  localparam logic [2:0] OP_BW     = 3'd3;
  localparam logic [2:0] OP_THRESH = 3'd4;

  localparam int BEAT_PIX = 2;
  localparam int DLY_W    = 16;

  // Unassigned operation codes fall back to pass-through.
  function automatic logic [2:0] op_sanitize(input logic [2:0] op);
    return (op > OP_THRESH) ? OP_PASS : op;
  endfunction

endpackage

// File: rtl/img_addr_gen.sv
// Row/column scan counters with an incrementally maintained row-base register.
module img_addr_gen import img_pkg::*; #(
  parameter int WIDTH     = 956,
  parameter int HEIGHT    = 635,
  parameter int BOTTOM_UP = 1,
  parameter int ADDR_W    = 20
) (
  input  logic                      HCLK,
  input  logic                      clr,
  input  logic                      load,
  input  logic                      adv,
  input  logic                      active,
  output logic [$clog2(HEIGHT)-1:0] row_o,
  output logic [$clog2(WIDTH)-1:0]  col_o,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic                      last_col,
  output logic                      last_row
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam logic [ADDR_W-1:0] BASE_FIRST = (BOTTOM_UP != 0) ? ADDR_W'((HEIGHT-1)*WIDTH) : '0;
  localparam logic [ADDR_W-1:0] ROW_STEP   = ADDR_W'(WIDTH);

  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [ADDR_W-1:0] base_q;
  logic              col_end, row_end;

  assign col_end = (col_q == CW'(WIDTH - BEAT_PIX));
  assign row_end = (row_q == RW'(HEIGHT - 1));

  // base_q always holds src_row*WIDTH, so the address needs only one adder.
  always_ff @(posedge HCLK) begin
    if (clr) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= '0;
    end else if (load) begin
      row_q  <= '0;
      col_q  <= '0;
      base_q <= BASE_FIRST;
    end else if (adv) begin
      if (col_end) begin
        col_q <= '0;
        if (row_end) begin
          row_q  <= '0;
          base_q <= '0;
        end else begin
          row_q  <= row_q + RW'(1);
          base_q <= (BOTTOM_UP != 0) ? base_q - ROW_STEP : base_q + ROW_STEP;
        end
      end else begin
        col_q <= col_q + CW'(BEAT_PIX);
      end
    end
  end

  assign row_o    = row_q;
  assign col_o    = col_q;
  assign rd_addr  = base_q + ADDR_W'(col_q);
  assign last_col = active & col_end;
  assign last_row = active & row_end;

endmodule

// File: rtl/img_scan_ctrl.sv
// Frame scan controller: config latch, VSYNC/HSYNC/DATA sequencing, abortable and back-pressure aware.
module img_scan_ctrl import img_pkg::*; #(
  parameter int WIDTH          = 956,
  parameter int HEIGHT         = 635,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int BOTTOM_UP      = 1,
  parameter int ADDR_W         = 20
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [2:0]                cfg_op_i,
  input  logic [7:0]                cfg_value_i,
  input  logic                      cfg_sign_i,
  input  logic [7:0]                cfg_thresh_i,
  output logic [2:0]                op_o,
  output logic [7:0]                value_o,
  output logic                      sign_o,
  output logic [7:0]                thresh_o,
  output logic                      VSYNC,
  output logic                      HSYNC,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_W-1:0]         rd_addr,
  output logic [$clog2(HEIGHT)-1:0] row_o,
  output logic [$clog2(WIDTH)-1:0]  col_o,
  output logic                      last_col,
  output logic                      last_row,
  output logic                      busy,
  output logic                      frame_done
);

  localparam logic [DLY_W-1:0] VS_LAST = DLY_W'(START_UP_DELAY - 1);
  localparam logic [DLY_W-1:0] HS_LAST = DLY_W'(HSYNC_DELAY - 1);

  scan_state_e      state, nxt;
  logic [DLY_W-1:0] dly_cnt;
  logic             kill, load, adv;

  assign kill = abort_i && (state != ST_IDLE);
  assign load = (state == ST_IDLE) && start_i;
  assign adv  = out_valid && out_ready;

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start_i) nxt = ST_VSYNC;
      ST_VSYNC: if (dly_cnt == VS_LAST) nxt = ST_HSYNC;
      ST_HSYNC: if (dly_cnt == HS_LAST) nxt = ST_DATA;
      ST_DATA:  if (out_ready && last_col) nxt = last_row ? ST_DONE : ST_HSYNC;
      ST_DONE:  nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
    if (kill) nxt = ST_IDLE;
  end

  // Status outputs are registered off the next state so they line up with state.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state      <= ST_IDLE;
      dly_cnt    <= '0;
      op_o       <= '0;
      value_o    <= '0;
      sign_o     <= 1'b0;
      thresh_o   <= '0;
      VSYNC      <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state   <= nxt;
      dly_cnt <= ((nxt == state) && (state == ST_VSYNC || state == ST_HSYNC))
                 ? dly_cnt + DLY_W'(1) : '0;
      if (load) begin
        op_o     <= op_sanitize(cfg_op_i);
        value_o  <= cfg_value_i;
        sign_o   <= cfg_sign_i;
        thresh_o <= cfg_thresh_i;
      end
      VSYNC      <= (nxt == ST_VSYNC);
      out_valid  <= (nxt == ST_DATA);
      busy       <= (nxt != ST_IDLE);
      frame_done <= (nxt == ST_DONE);
    end
  end

  assign HSYNC = out_valid;

  img_addr_gen #(
    .WIDTH     (WIDTH),
    .HEIGHT    (HEIGHT),
    .BOTTOM_UP (BOTTOM_UP),
    .ADDR_W    (ADDR_W)
  ) u_addr (
    .HCLK     (HCLK),
    .clr      (HRESET | kill),
    .load     (load),
    .adv      (adv),
    .active   (busy),
    .row_o    (row_o),
    .col_o    (col_o),
    .rd_addr  (rd_addr),
    .last_col (last_col),
    .last_row (last_row)
  );

endmodule

// File: tb/tb_img_scan_ctrl.sv
// Bench for img_scan_ctrl: beat-index model checked every cycle plus literal frame expectations.
module tb_img_scan_ctrl;

  localparam int W = 8, H = 4, SUD = 3, HSD = 2, AW = 5;
  localparam int BPR = W / 2, TOT = H * BPR;

  logic HCLK = 0, HRESET = 1, start_i = 0, abort_i = 0, out_ready = 1;
  logic [2:0] cfg_op_i = 0;
  logic [7:0] cfg_value_i = 0, cfg_thresh_i = 0;
  logic       cfg_sign_i = 0;

  logic [2:0] op_o, t_op_o;
  logic [7:0] value_o, thresh_o, t_value_o, t_thresh_o;
  logic       sign_o, VSYNC, HSYNC, out_valid, last_col, last_row, busy, frame_done;
  logic       t_sign_o, t_VSYNC, t_HSYNC, t_out_valid, t_last_col, t_last_row, t_busy, t_frame_done;
  logic [AW-1:0] rd_addr, t_rd_addr;
  logic [1:0] row_o, t_row_o;
  logic [2:0] col_o, t_col_o;

  img_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD),
                  .BOTTOM_UP(1), .ADDR_W(AW)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start_i(start_i), .abort_i(abort_i),
    .cfg_op_i(cfg_op_i), .cfg_value_i(cfg_value_i), .cfg_sign_i(cfg_sign_i), .cfg_thresh_i(cfg_thresh_i),
    .op_o(op_o), .value_o(value_o), .sign_o(sign_o), .thresh_o(thresh_o),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .out_valid(out_valid), .out_ready(out_ready),
    .rd_addr(rd_addr), .row_o(row_o), .col_o(col_o), .last_col(last_col), .last_row(last_row),
    .busy(busy), .frame_done(frame_done));

  img_scan_ctrl #(.WIDTH(W), .HEIGHT(H), .START_UP_DELAY(SUD), .HSYNC_DELAY(HSD),
                  .BOTTOM_UP(0), .ADDR_W(AW)) dut_td (
    .HCLK(HCLK), .HRESET(HRESET), .start_i(start_i), .abort_i(abort_i),
    .cfg_op_i(cfg_op_i), .cfg_value_i(cfg_value_i), .cfg_sign_i(cfg_sign_i), .cfg_thresh_i(cfg_thresh_i),
    .op_o(t_op_o), .value_o(t_value_o), .sign_o(t_sign_o), .thresh_o(t_thresh_o),
    .VSYNC(t_VSYNC), .HSYNC(t_HSYNC), .out_valid(t_out_valid), .out_ready(out_ready),
    .rd_addr(t_rd_addr), .row_o(t_row_o), .col_o(t_col_o), .last_col(t_last_col), .last_row(t_last_row),
    .busy(t_busy), .frame_done(t_frame_done));

  always #5 HCLK = ~HCLK;

  int cyc = 0, t0 = 0, total = 0, bad = 0;
  bit armed = 0;
  // model: phase 0 idle, 1 vsync, 2 gap, 3 data, 4 done; m_k = completed beats this frame
  int m_ph = 0, m_left = 0, m_k = 0;
  logic [2:0] m_op = 0;
  logic [7:0] m_val = 0, m_thr = 0;
  logic       m_sign = 0;
  int q_bu[$], q_td[$];
  int done_cnt = 0, done_rel = -1, first_rel = -1, fall_rel = -1;
  logic prev_busy = 0;
  int er, ec;
  int exp_bu[16] = '{24, 26, 28, 30, 16, 18, 20, 22, 8, 10, 12, 14, 0, 2, 4, 6};
  int exp_td[16] = '{0, 2, 4, 6, 8, 10, 12, 14, 16, 18, 20, 22, 24, 26, 28, 30};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d rel=%0d", nm, act, exp, cyc - t0);
    end
  endtask

  always @(posedge HCLK) begin
    cyc++;
    if (HRESET) begin
      armed = 1; m_ph = 0; m_k = 0; m_left = 0;
      m_op = 0; m_val = 0; m_thr = 0; m_sign = 0;
    end else if (armed) begin
      if (abort_i && m_ph != 0) begin
        m_ph = 0; m_k = 0;
      end else begin
        case (m_ph)
          0: if (start_i) begin
               m_op = (cfg_op_i > 4) ? 3'd0 : cfg_op_i;
               m_val = cfg_value_i; m_sign = cfg_sign_i; m_thr = cfg_thresh_i;
               m_ph = 1; m_left = SUD; m_k = 0;
             end
          1: begin m_left--; if (m_left == 0) begin m_ph = 2; m_left = HSD; end end
          2: begin m_left--; if (m_left == 0) m_ph = 3; end
          3: if (out_ready) begin
               m_k++;
               if (m_k % BPR == 0) begin
                 if (m_k == TOT) m_ph = 4;
                 else begin m_ph = 2; m_left = HSD; end
               end
             end
          default: begin m_ph = 0; m_k = 0; end
        endcase
      end
    end
  end

  always @(negedge HCLK) if (armed) begin
    chk("vsync", VSYNC, m_ph == 1);
    chk("hsync", HSYNC, m_ph == 3);
    chk("valid", out_valid, m_ph == 3);
    chk("busy", busy, m_ph != 0);
    chk("done", frame_done, m_ph == 4);
    chk("busy_td", t_busy, m_ph != 0);
    chk("done_td", t_frame_done, m_ph == 4);
    chk("op", op_o, m_op);
    chk("value", value_o, m_val);
    chk("sign", sign_o, m_sign);
    chk("thresh", thresh_o, m_thr);
    if (m_ph == 3) begin
      er = m_k / BPR; ec = 2 * (m_k % BPR);
      chk("addr_bu", rd_addr, (H - 1 - er) * W + ec);
      chk("addr_td", t_rd_addr, er * W + ec);
      chk("row", row_o, er);
      chk("col", col_o, ec);
      chk("last_col", last_col, ec == W - 2);
      chk("last_row", last_row, er == H - 1);
    end else if (m_ph == 0) begin
      chk("idle_addr", rd_addr, 0);
      chk("idle_addr_td", t_rd_addr, 0);
      chk("idle_row", row_o, 0);
      chk("idle_col", col_o, 0);
      chk("idle_last", {last_col, last_row}, 0);
    end
    if (frame_done) begin done_cnt++; done_rel = cyc - t0; end
    if (out_valid && out_ready) begin
      q_bu.push_back(int'(rd_addr));
      q_td.push_back(int'(t_rd_addr));
      if (first_rel < 0) first_rel = cyc - t0;
    end
    if (prev_busy && !busy) fall_rel = cyc - t0;
    prev_busy = busy;
  end

  task automatic tick();
    @(posedge HCLK); #2;
  endtask

  task automatic start_frame(input logic [2:0] op, input logic [7:0] thr);
    q_bu.delete(); q_td.delete();
    done_cnt = 0; done_rel = -1; first_rel = -1; fall_rel = -1;
    cfg_op_i = op; cfg_thresh_i = thr; cfg_value_i = 8'd10; cfg_sign_i = 1;
    start_i = 1; t0 = cyc;
    tick();
    start_i = 0;
  endtask

  task automatic wait_rel(input int n);
    for (int i = 0; i < 200 && (cyc - t0) < n; i++) tick();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  task automatic chk_seq();
    chk("nbeats_bu", q_bu.size(), TOT);
    chk("nbeats_td", q_td.size(), TOT);
    for (int i = 0; i < TOT; i++) begin
      if (i < q_bu.size()) chk("seq_bu", q_bu[i], exp_bu[i]);
      if (i < q_td.size()) chk("seq_td", q_td[i], exp_td[i]);
    end
  endtask

  initial begin
    HRESET = 1; tick(); tick();
    HRESET = 0; tick();
    chk("rst_busy", busy, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_op", op_o, 0);

    // plain frame, threshold config, mid-frame config change
    start_frame(3'd4, 8'd90);
    chk("lat_op", op_o, 4);
    chk("lat_thr", thresh_o, 90);
    chk("vs_first", VSYNC, 1);
    wait_rel(10); cfg_op_i = 3'd2;
    wait_rel(12); chk("op_hold", op_o, 4);
    wait_idle();
    chk("done_rel", done_rel, 28);
    chk("fall_rel", fall_rel, 29);
    chk("first_beat", first_rel, 6);
    chk("done_cnt", done_cnt, 1);
    chk_seq();

    // back-pressure on the second beat, op 6 maps to pass
    start_frame(3'd6, 8'd0);
    chk("op6_pass", op_o, 0);
    wait_rel(7);
    out_ready = 0;
    repeat (3) begin chk("stall_addr", rd_addr, 26); tick(); end
    out_ready = 1;
    wait_idle();
    chk("bp_done_rel", done_rel, 31);
    chk_seq();

    // abort during row 2, then restart with start+abort together
    start_frame(3'd1, 8'd0);
    wait_rel(19);
    abort_i = 1; tick(); abort_i = 0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    repeat (5) tick();
    chk("abort_nodone", done_cnt, 0);
    abort_i = 1;
    start_frame(3'd1, 8'd0);
    abort_i = 0;
    chk("start_wins", busy, 1);
    wait_idle();
    chk("re_done_rel", done_rel, 28);
    chk_seq();

    // start re-pulsed during DATA is ignored
    start_frame(3'd2, 8'd7);
    wait_rel(7);
    start_i = 1; tick(); start_i = 0;
    wait_idle();
    chk("ign_done_rel", done_rel, 28);
    chk("ign_done_cnt", done_cnt, 1);
    chk_seq();

    // reset mid-VSYNC clears everything including config
    start_frame(3'd3, 8'd55);
    chk("bw_op", op_o, 3);
    wait_rel(2);
    HRESET = 1; tick(); HRESET = 0;
    chk("mrst_vsync", VSYNC, 0);
    chk("mrst_op", op_o, 0);
    chk("mrst_thr", thresh_o, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_addr", rd_addr, 0);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/img_scan_ctrl.md
Name: img_scan_ctrl

Overview:
- Frame scan controller that sequences the pixel-processing datapath of the image pipeline.
- On a start request it latches the operation configuration, then produces the frame timing: a VSYNC start-up window, then per row an HSYNC gap followed by a data phase.
- In the data phase it issues one two-pixel read address per beat to the pixel store/processing datapath under a valid/ready handshake, and signals frame completion.
- It replaces free-running timing with a restartable, abortable, back-pressure-aware scheduler.

Parameters:
WIDTH, 956, image width in pixels; must be even (two pixels per beat)
HEIGHT, 635, image height in rows
START_UP_DELAY, 100, VSYNC window length in cycles (>=1)
HSYNC_DELAY, 160, gap before each row's data phase in cycles (>=1)
BOTTOM_UP, 1, 1 = source rows read HEIGHT-1 down to 0 (bottom-up file order); 0 = top-down
ADDR_W, 20, pixel address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
HCLK  in  1  clock
HRESET  in  1  synchronous active-high reset
start_i  in  1  frame start request; sampled only in IDLE
abort_i  in  1  abandon current frame
cfg_op_i  in  3  operation: 0 pass, 1 brightness, 2 invert, 3 black-and-white, 4 threshold; 5-7 treated as pass
cfg_value_i  in  8  brightness offset
cfg_sign_i  in  1  1 = add, 0 = subtract
cfg_thresh_i  in  8  threshold level
op_o  out  3  latched operation to datapath
value_o  out  8  latched offset
sign_o  out  1  latched sign
thresh_o  out  8  latched threshold
VSYNC  out  1  high during the VSYNC state
HSYNC  out  1  high during the DATA state (data-enable); identical to out_valid
out_valid  out  1  beat valid
out_ready  in  1  downstream accepts beat
rd_addr  out  ADDR_W  pixel index of the even pixel (the odd pixel is rd_addr+1)
row_o  out  clog2(HEIGHT)  output row index, 0 = first emitted
col_o  out  clog2(WIDTH)  even column index
last_col  out  1  current beat is the last of its row
last_row  out  1  current row is the last row
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (sync, HRESET=1): state IDLE; all outputs 0; counters, row and column cleared; latched config cleared to 0.
- States: IDLE, VSYNC, HSYNC, DATA, DONE.
- IDLE: when start_i=1, latch all cfg_* values and go to VSYNC. Config is held constant until the next start.
- VSYNC: VSYNC=1 for exactly START_UP_DELAY cycles, then HSYNC.
- HSYNC (gap): HSYNC=0 for exactly HSYNC_DELAY cycles, then DATA.
- DATA: out_valid=1. A beat completes when out_valid and out_ready are both 1.
  - While out_ready=0, rd_addr, row_o and col_o hold.
  - On a completed beat: col advances by 2.
  - On a completed beat with last_col: col resets to 0 and row increments; the state goes to HSYNC, or to DONE if last_row.
- DONE: frame_done=1 for one cycle, then IDLE.
- Address rule: src_row = BOTTOM_UP ? HEIGHT-1-row : row; rd_addr = src_row*WIDTH + col.
  - rd_addr is computed from the registered row and column, so it is valid in the same cycle as out_valid.
  - A multiply is acceptable; an incrementally maintained row-base register is preferred.
- Latency: the first VSYNC cycle is the cycle after start_i is sampled.
- With out_ready held at 1, a frame takes 1 + START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) cycles from start sample to DONE.
- start_i outside IDLE is ignored; no queuing.
- abort_i has priority over every transition in all non-IDLE states:
  - next state is IDLE; counters, row and column cleared; no frame_done.
  - abort_i in IDLE has no effect.
  - abort_i together with start_i in IDLE: start wins.
- Reset asserted mid-frame behaves like abort and additionally clears the config.
- Delay counters are 16 bits; they count 0..DELAY-1 and compare at DELAY-1.

Decomposition:
- Shared package img_pkg:
  - op encodings OP_PASS, OP_BRIGHT, OP_INVERT, OP_BW, OP_THRESH;
  - state encoding type;
  - the two-pixel beat width constant.
- One natural sub-module, img_addr_gen: row/column counters, row-base register, BOTTOM_UP flip, last_col/last_row flags. The FSM and config latch stay in the top module.

Test Plan (WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2, BOTTOM_UP=1, out_ready=1 unless stated):
1. start_i pulsed at cycle 0:
   - VSYNC=1 on cycles 1-3; data beats on cycles 6-9, 12-15, 18-21, 24-27.
   - frame_done=1 on cycle 28 only; busy falls on cycle 29; 16 beats total.
2. Address order in scenario 1: rd_addr = 24,26,28,30, 16,18,20,22, 8,10,12,14, 0,2,4,6. Same run with BOTTOM_UP=0: 0,2,...,30.
3. Back-pressure: out_ready=0 for 3 cycles at the second beat (rd_addr=26) -> rd_addr holds at 26, no beat is skipped or duplicated, and frame_done is delayed by exactly 3 cycles.
4. Config latch:
   - cfg_op_i=4, cfg_thresh_i=90 at start -> op_o=4, thresh_o=90.
   - Inputs then change to op 2 mid-frame -> op_o stays 4 until the next start.
   - cfg_op_i=6 -> op_o=0 (pass).
5. abort_i pulsed during row 2 -> IDLE next cycle, out_valid=0, no frame_done.
   - A following start produces the full 16-beat sequence from rd_addr=24.
6. start_i re-pulsed while in DATA -> ignored, frame unchanged. HRESET asserted mid-VSYNC -> all outputs 0 next cycle, op_o=0.
